flash_bus_arbiter: RTL and testbench



---
 rtl/flash_arb_pkg.sv | 33 +++
 rtl/flash_arb_pin_mux.sv | 67 ++++++
 rtl/flash_bus_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_flash_bus_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_arb_pkg.sv
// -----------------------------------------------------------------------------
// flash_arb_pkg
// Shared types and constants for the configuration-flash bus arbiter.
//   arb_state_e : ownership state of the flash pins
//   owner_e     : identity of a requester (used for round-robin tie-break)
//   DQ_IDLE_*   : pin values while nobody owns the flash (HOLD/WP driven high)
//   is_owned()  : true when a state hands the pins to a requester
// -----------------------------------------------------------------------------
package flash_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWN_SPI  = 2'd1,
        OWN_QSPI = 2'd2,
        GAP      = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_SPI_ID  = 1'b0,
        OWN_QSPI_ID = 1'b1
    } owner_e;

    localparam logic [3:0] DQ_IDLE_OUT = 4'b1100;
    localparam logic [3:0] DQ_IDLE_OE  = 4'b1100;

    // Gap counter width: GAP_CYCLES is limited to 1..15
    localparam int GAP_CNT_W = 4;

    function automatic logic is_owned(input arb_state_e s);
        return (s == OWN_SPI) || (s == OWN_QSPI);
    endfunction

endpackage

// File: rtl/flash_arb_pin_mux.sv
// -----------------------------------------------------------------------------
// flash_arb_pin_mux
// Purely combinational mapping of the registered arbiter state plus the two
// requesters' pin signals onto the flash pin vectors. Only the owner's pins
// reach the flash; in IDLE/GAP CS_n is high, SCK low, HOLD/WP driven high.
// Ports:
//   state_i                      registered arbiter state (arb_state_e)
//   spi_csn_i/sck_i/mosi_i       1-bit SPI master pins
//   qspi_ncs_i/dclk_i/oe_i       QSPI controller control (oe_i active-low)
//   qspi_dataout_i/dataoe_i      QSPI per-lane data and lane enables
//   flash_csn_o/sck_o            flash CS_n and clock pin values
//   flash_dq_out_o/dq_oe_o       DQ[3:0] values and drive enables
// -----------------------------------------------------------------------------
module flash_arb_pin_mux
    import flash_arb_pkg::*;
(
    input  logic [1:0] state_i,
    input  logic       spi_csn_i,
    input  logic       spi_sck_i,
    input  logic       spi_mosi_i,
    input  logic       qspi_ncs_i,
    input  logic       qspi_dclk_i,
    input  logic       qspi_oe_i,
    input  logic [3:0] qspi_dataout_i,
    input  logic [3:0] qspi_dataoe_i,
    output logic       flash_csn_o,
    output logic       flash_sck_o,
    output logic [3:0] flash_dq_out_o,
    output logic [3:0] flash_dq_oe_o
);

    // Select the owner's pins; idle values otherwise
    always_comb begin
        flash_csn_o    = 1'b1;
        flash_sck_o    = 1'b0;
        flash_dq_out_o = DQ_IDLE_OUT;
        flash_dq_oe_o  = DQ_IDLE_OE;
        case (arb_state_e'(state_i))
            OWN_SPI: begin
                // Single-lane SPI: DQ0=MOSI driven, DQ1=MISO input, HOLD/WP high
                flash_csn_o    = spi_csn_i;
                flash_sck_o    = spi_sck_i;
                flash_dq_out_o = {2'b11, 1'b0, spi_mosi_i};
                flash_dq_oe_o  = 4'b1101;
            end
            OWN_QSPI: begin
                flash_csn_o = qspi_ncs_i;
                flash_sck_o = qspi_dclk_i & ~qspi_oe_i;
                if (qspi_oe_i) begin
                    // Controller outputs disabled: keep HOLD/WP driven high
                    flash_dq_out_o = {2'b11, qspi_dataout_i[1:0]};
                    flash_dq_oe_o  = 4'b1100;
                end else begin
                    flash_dq_out_o = qspi_dataout_i;
                    flash_dq_oe_o  = qspi_dataoe_i;
                end
            end
            default: begin
                flash_csn_o    = 1'b1;
                flash_sck_o    = 1'b0;
                flash_dq_out_o = DQ_IDLE_OUT;
                flash_dq_oe_o  = DQ_IDLE_OE;
            end
        endcase
    end

endmodule

// File: rtl/flash_bus_arbiter.sv
// -----------------------------------------------------------------------------
// flash_bus_arbiter
// Shares one quad-SPI configuration flash between the SAM's 1-bit SPI master
// (requester 0) and the soft-core's QSPI controller (requester 1). One owner
// at a time, round-robin on ties, and a CS_n-high gap of GAP_CYCLES between
// owners. A transfer is never cut: release needs REQ low and CS_n high.
// Optional feature macro: FLASH_ARB_TIMEOUT_EN (forced release after
// TIMEOUT_CYCLES owned cycles, oTIMEOUT pulse, evicted requester must drop
// REQ once before being granted again).
// Ports:
//   iCLK, iRESETn                       clock, async active-low reset
//   iSPI_*, oSPI_GNT, oSPI_MISO         SPI master side
//   iQSPI_*, oQSPI_GNT, oQSPI_DATAIN    QSPI controller side
//   oFLASH_*, iFLASH_DQ_IN              flash pin values / enables / readback
//   oTIMEOUT                            one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module flash_bus_arbiter
    import flash_arb_pkg::*;
#(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int TO_W           = 17
) (
    input  logic       iCLK,
    input  logic       iRESETn,
    input  logic       iSPI_REQ,
    output logic       oSPI_GNT,
    input  logic       iSPI_CSn,
    input  logic       iSPI_SCK,
    input  logic       iSPI_MOSI,
    output logic       oSPI_MISO,
    input  logic       iQSPI_REQ,
    output logic       oQSPI_GNT,
    input  logic       iQSPI_NCS,
    input  logic       iQSPI_DCLK,
    input  logic       iQSPI_OE,
    input  logic [3:0] iQSPI_DATAOUT,
    input  logic [3:0] iQSPI_DATAOE,
    output logic [3:0] oQSPI_DATAIN,
    output logic       oFLASH_SCK,
    output logic       oFLASH_CSn,
    output logic [3:0] oFLASH_DQ_OUT,
    output logic [3:0] oFLASH_DQ_OE,
    input  logic [3:0] iFLASH_DQ_IN,
    output logic       oTIMEOUT
);

    arb_state_e             state_q, state_d;
    owner_e                 last_q, last_d;
    logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic                   spi_gnt_q, qspi_gnt_q;
    logic                   spi_req_s, qspi_req_s;
    logic                   to_hit_s;

`ifdef FLASH_ARB_TIMEOUT_EN
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   timeout_q;
    logic                   spi_blk_q, spi_blk_d;
    logic                   qspi_blk_q, qspi_blk_d;

    // An evicted requester stays masked until its REQ has been seen low
    assign spi_req_s  = iSPI_REQ & ~spi_blk_q;
    assign qspi_req_s = iQSPI_REQ & ~qspi_blk_q;
    assign to_hit_s   = is_owned(state_q) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign oTIMEOUT   = timeout_q;

    // Ownership-length counter and eviction masks
    always_comb begin
        to_cnt_d   = '0;
        spi_blk_d  = spi_blk_q;
        qspi_blk_d = qspi_blk_q;
        if (is_owned(state_q) && (state_d == state_q)) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_d = '0;
        end
        if (to_hit_s && (state_q == OWN_SPI)) begin
            spi_blk_d = 1'b1;
        end else if (!iSPI_REQ) begin
            spi_blk_d = 1'b0;
        end else begin
            spi_blk_d = spi_blk_q;
        end
        if (to_hit_s && (state_q == OWN_QSPI)) begin
            qspi_blk_d = 1'b1;
        end else if (!iQSPI_REQ) begin
            qspi_blk_d = 1'b0;
        end else begin
            qspi_blk_d = qspi_blk_q;
        end
    end

    // Timeout state registers
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            to_cnt_q   <= '0;
            timeout_q  <= 1'b0;
            spi_blk_q  <= 1'b0;
            qspi_blk_q <= 1'b0;
        end else begin
            to_cnt_q   <= to_cnt_d;
            timeout_q  <= to_hit_s;
            spi_blk_q  <= spi_blk_d;
            qspi_blk_q <= qspi_blk_d;
        end
    end
`else
    logic [TO_W-1:0]        to_unused_s;

    assign to_unused_s = TO_W'(TIMEOUT_CYCLES - 1);
    assign spi_req_s   = iSPI_REQ;
    assign qspi_req_s  = iQSPI_REQ;
    assign to_hit_s    = 1'b0;
    assign oTIMEOUT    = 1'b0;
`endif

    // Arbitration FSM next state, gap counter and round-robin pointer
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gap_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (spi_req_s && qspi_req_s) begin
                    if (last_q == OWN_QSPI_ID) begin
                        state_d = OWN_SPI;
                        last_d  = OWN_SPI_ID;
                    end else begin
                        state_d = OWN_QSPI;
                        last_d  = OWN_QSPI_ID;
                    end
                end else if (spi_req_s) begin
                    state_d = OWN_SPI;
                    last_d  = OWN_SPI_ID;
                end else if (qspi_req_s) begin
                    state_d = OWN_QSPI;
                    last_d  = OWN_QSPI_ID;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN_SPI: begin
                // last_q already names the evicted owner on a forced release
                if (to_hit_s || (!iSPI_REQ && iSPI_CSn)) begin
                    state_d = GAP;
                end else begin
                    state_d = OWN_SPI;
                end
            end
            OWN_QSPI: begin
                if (to_hit_s || (!iQSPI_REQ && iQSPI_NCS)) begin
                    state_d = GAP;
                end else begin
                    state_d = OWN_QSPI;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    state_d   = GAP;
                    gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, pointer, gap counter and registered grants
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state_q    <= IDLE;
            last_q     <= OWN_QSPI_ID;
            gap_cnt_q  <= '0;
            spi_gnt_q  <= 1'b0;
            qspi_gnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gap_cnt_q  <= gap_cnt_d;
            spi_gnt_q  <= (state_d == OWN_SPI);
            qspi_gnt_q <= (state_d == OWN_QSPI);
        end
    end

    assign oSPI_GNT     = spi_gnt_q;
    assign oQSPI_GNT    = qspi_gnt_q;
    assign oSPI_MISO    = iFLASH_DQ_IN[1];
    assign oQSPI_DATAIN = iFLASH_DQ_IN;

    flash_arb_pin_mux u_pin_mux (
        .state_i        (state_q),
        .spi_csn_i      (iSPI_CSn),
        .spi_sck_i      (iSPI_SCK),
        .spi_mosi_i     (iSPI_MOSI),
        .qspi_ncs_i     (iQSPI_NCS),
        .qspi_dclk_i    (iQSPI_DCLK),
        .qspi_oe_i      (iQSPI_OE),
        .qspi_dataout_i (iQSPI_DATAOUT),
        .qspi_dataoe_i  (iQSPI_DATAOE),
        .flash_csn_o    (oFLASH_CSn),
        .flash_sck_o    (oFLASH_SCK),
        .flash_dq_out_o (oFLASH_DQ_OUT),
        .flash_dq_oe_o  (oFLASH_DQ_OE)
    );

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_flash_bus_arbiter
// Directed bench for flash_bus_arbiter: a table of pin-mux vectors applied
// while each requester owns the flash, plus hand-written sequences for grant
// latency, hold-until-CS-high, gap timing, round-robin, async reset and the
// timeout behaviour (FLASH_ARB_TIMEOUT_EN selects which timeout checks run).
// -----------------------------------------------------------------------------
module tb_flash_bus_arbiter;

    localparam int GAP = 2;
`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int HOLD_CYC = 10;
`else
    localparam int HOLD_CYC = 20;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_req, spi_csn, spi_sck, spi_mosi;
    logic       q_req, q_ncs, q_dclk, q_oe;
    logic [3:0] q_dout, q_doe, dq_in;
    logic       spi_gnt, spi_miso, q_gnt, f_sck, f_csn, tmo;
    logic [3:0] q_datain, f_dq_out, f_dq_oe;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct packed {
        logic       owner;
        logic       spi_csn, spi_sck, spi_mosi;
        logic       q_ncs, q_dclk, q_oe;
        logic [3:0] q_dout, q_doe, dq_in;
        logic       exp_csn, exp_sck;
        logic [3:0] exp_out, exp_oe;
        logic       exp_miso;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    flash_bus_arbiter #(
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (16),
        .TO_W           (17)
    ) dut (
        .iCLK          (clk),
        .iRESETn       (rst_n),
        .iSPI_REQ      (spi_req),
        .oSPI_GNT      (spi_gnt),
        .iSPI_CSn      (spi_csn),
        .iSPI_SCK      (spi_sck),
        .iSPI_MOSI     (spi_mosi),
        .oSPI_MISO     (spi_miso),
        .iQSPI_REQ     (q_req),
        .oQSPI_GNT     (q_gnt),
        .iQSPI_NCS     (q_ncs),
        .iQSPI_DCLK    (q_dclk),
        .iQSPI_OE      (q_oe),
        .iQSPI_DATAOUT (q_dout),
        .iQSPI_DATAOE  (q_doe),
        .oQSPI_DATAIN  (q_datain),
        .oFLASH_SCK    (f_sck),
        .oFLASH_CSn    (f_csn),
        .oFLASH_DQ_OUT (f_dq_out),
        .oFLASH_DQ_OE  (f_dq_oe),
        .iFLASH_DQ_IN  (dq_in),
        .oTIMEOUT      (tmo)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_vecs(input logic owner);
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].owner == owner) begin
                spi_csn  = vecs[i].spi_csn;
                spi_sck  = vecs[i].spi_sck;
                spi_mosi = vecs[i].spi_mosi;
                q_ncs    = vecs[i].q_ncs;
                q_dclk   = vecs[i].q_dclk;
                q_oe     = vecs[i].q_oe;
                q_dout   = vecs[i].q_dout;
                q_doe    = vecs[i].q_doe;
                dq_in    = vecs[i].dq_in;
                #1;
                check($sformatf("vec%0d csn", i), 8'(f_csn), 8'(vecs[i].exp_csn));
                check($sformatf("vec%0d sck", i), 8'(f_sck), 8'(vecs[i].exp_sck));
                check($sformatf("vec%0d dq_out", i), 8'(f_dq_out), 8'(vecs[i].exp_out));
                check($sformatf("vec%0d dq_oe", i), 8'(f_dq_oe), 8'(vecs[i].exp_oe));
                check($sformatf("vec%0d miso", i), 8'(spi_miso), 8'(vecs[i].exp_miso));
                check($sformatf("vec%0d qspi_datain", i), 8'(q_datain), 8'(vecs[i].dq_in));
            end
        end
    endtask

    // Count cycles from the release drive until QSPI is granted; CS_n must stay high meanwhile
    task automatic handoff_to_qspi(input string name);
        int  n;
        logic gap_ok;
        step();
        check({name, " spi gnt drop"}, 8'(spi_gnt), 8'd0);
        n      = 1;
        gap_ok = 1'b1;
        while (!q_gnt && n < 20) begin
            if (f_csn !== 1'b1) gap_ok = 1'b0;
            step();
            n++;
        end
        check({name, " handoff latency"}, 8'(n), 8'(GAP + 2));
        check({name, " csn high in gap"}, 8'(gap_ok), 8'd1);
    endtask

    // Global run-time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int held;
        int n;
        logic seen;
        //            own  scn sck mo  ncs dck qoe dout  doe   dq    ecs esk eout     eoe      emiso
        vecs[0] = '{1'b0, 1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 4'hF,4'hF,4'hA, 1'b0,1'b0,4'b1101,4'b1101,1'b1};
        vecs[1] = '{1'b0, 1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0, 4'h0,4'hF,4'h5, 1'b0,1'b1,4'b1100,4'b1101,1'b0};
        vecs[2] = '{1'b0, 1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0, 4'hF,4'hF,4'h2, 1'b1,1'b0,4'b1101,4'b1101,1'b1};
        vecs[3] = '{1'b1, 1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0, 4'h0,4'h0,4'hA, 1'b0,1'b1,4'b0000,4'b0000,1'b1};
        vecs[4] = '{1'b1, 1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0, 4'h5,4'hF,4'h3, 1'b0,1'b1,4'b0101,4'b1111,1'b1};
        vecs[5] = '{1'b1, 1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1, 4'h0,4'hF,4'h0, 1'b0,1'b0,4'b1100,4'b1100,1'b0};
        vecs[6] = '{1'b1, 1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0, 4'hA,4'h3,4'hC, 1'b1,1'b0,4'b1010,4'b0011,1'b0};

        rst_n = 1'b0;
        spi_req = 1'b0; spi_csn = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        q_req = 1'b0; q_ncs = 1'b1; q_dclk = 1'b0; q_oe = 1'b1;
        q_dout = 4'h0; q_doe = 4'h0; dq_in = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset spi_gnt", 8'(spi_gnt), 8'd0);
        check("reset qspi_gnt", 8'(q_gnt), 8'd0);
        check("reset timeout", 8'(tmo), 8'd0);
        check("reset csn", 8'(f_csn), 8'd1);
        check("reset sck", 8'(f_sck), 8'd0);
        check("reset dq_out", 8'(f_dq_out), 8'h0C);
        check("reset dq_oe", 8'(f_dq_oe), 8'h0C);
        rst_n = 1'b1;
        repeat (5) step();

        // Single SPI request: grant one cycle after REQ is sampled
        spi_req = 1'b1;
        spi_csn = 1'b0;
        check("spi gnt before edge", 8'(spi_gnt), 8'd0);
        step();
        check("spi gnt latency", 8'(spi_gnt), 8'd1);
        check("qspi not granted", 8'(q_gnt), 8'd0);
        apply_vecs(1'b0);

        // REQ low but CS_n low: grant held; QSPI waits and its CS activity is ignored
        spi_csn = 1'b0;
        spi_req = 1'b0;
        q_req   = 1'b1;
        held    = 0;
        for (int i = 0; i < HOLD_CYC; i++) begin
            q_ncs = i[0];
            step();
            if (spi_gnt === 1'b1 && f_csn === 1'b0 && q_gnt === 1'b0) held++;
        end
        check("grant held while csn low", 8'(held), 8'(HOLD_CYC));
        q_ncs   = 1'b0;
        spi_csn = 1'b1;
        handoff_to_qspi("spi->qspi");
        apply_vecs(1'b1);

        // Async reset in the middle of a QSPI transfer
        step();
        q_ncs = 1'b0; q_oe = 1'b0; q_dout = 4'hF; q_doe = 4'hF;
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset csn", 8'(f_csn), 8'd1);
        check("async reset dq_oe", 8'(f_dq_oe), 8'h0C);
        check("async reset qspi_gnt", 8'(q_gnt), 8'd0);
        check("async reset spi_gnt", 8'(spi_gnt), 8'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        spi_req = 1'b1;
        spi_csn = 1'b0;
        q_req   = 1'b1;

        // Tie after reset: SPI first
        step();
        check("tie after reset spi", 8'(spi_gnt), 8'd1);
        check("tie after reset qspi", 8'(q_gnt), 8'd0);
        spi_req = 1'b0;
        spi_csn = 1'b1;
        handoff_to_qspi("tie handoff");

        // QSPI releases; next tie goes to SPI
        q_req = 1'b0; q_ncs = 1'b1;
        step();
        check("qspi release", 8'(q_gnt), 8'd0);
        repeat (4) step();
        spi_req = 1'b1; spi_csn = 1'b0; q_req = 1'b1; q_ncs = 1'b0;
        step();
        check("tie2 spi", 8'(spi_gnt), 8'd1);
        check("tie2 qspi", 8'(q_gnt), 8'd0);

        // SPI releases with nobody waiting; next tie goes to QSPI
        spi_req = 1'b0; spi_csn = 1'b1; q_req = 1'b0; q_ncs = 1'b1;
        repeat (5) step();
        check("idle after release", 8'({spi_gnt, q_gnt}), 8'd0);
        spi_req = 1'b1; spi_csn = 1'b0; q_req = 1'b1; q_ncs = 1'b0;
        step();
        check("tie3 qspi", 8'(q_gnt), 8'd1);
        check("tie3 spi", 8'(spi_gnt), 8'd0);
        check("tie3 csn from qspi", 8'(f_csn), 8'd0);

        // QSPI releases; SPI already waiting (last owner QSPI) holds REQ and CS_n low
        q_req = 1'b0; q_ncs = 1'b1;
        n = 0;
        while (!spi_gnt && n < 20) begin
            step();
            n++;
        end
        check("qspi->spi handoff latency", 8'(n), 8'(GAP + 2));
        q_req = 1'b1;
`ifdef FLASH_ARB_TIMEOUT_EN
        // Forced release after 16 owned cycles, QSPI granted next, SPI masked
        n = 0;
        while (!tmo && n < 40) begin
            step();
            n++;
        end
        check("timeout after owned cycles", 8'(n), 8'd16);
        check("timeout drops spi gnt", 8'(spi_gnt), 8'd0);
        step();
        check("timeout pulse width", 8'(tmo), 8'd0);
        n = 1;
        while (!q_gnt && n < 20) begin
            step();
            n++;
        end
        check("qspi granted after timeout", 8'(n), 8'd3);
        q_req = 1'b0; q_ncs = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            step();
            if (spi_gnt) seen = 1'b1;
        end
        check("evicted spi masked", 8'(seen), 8'd0);
`else
        // No timeout: SPI keeps the grant indefinitely, oTIMEOUT stays low
        seen = 1'b0;
        held = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tmo) seen = 1'b1;
            if (spi_gnt === 1'b1 && q_gnt === 1'b0) held++;
        end
        check("no timeout pulse", 8'(seen), 8'd0);
        check("spi keeps grant", 8'(held), 8'd40);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
